// File: rtl/cordic_result_buffer.sv
`timescale 1ns/1ps
// Result buffer behind the stall-free pipelined CORDIC core: FWFT FIFO of result
// tuples plus an issue-credit tracker so the upstream never outruns free slots.
module cordic_result_buffer #(
  parameter int BITS  = 33,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_issue,
  input  logic            i_valid,
  input  logic [BITS-1:0] i_x,
  input  logic [BITS-1:0] i_y,
  input  logic [BITS-1:0] i_z,
  input  logic [1:0]      i_mode,
  input  logic            i_rot_en,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [BITS-1:0] o_x,
  output logic [BITS-1:0] o_y,
  output logic [BITS-1:0] o_z,
  output logic [1:0]      o_mode,
  output logic            o_rot_en,
  output logic [CW-1:0]   o_count,
  output logic [CW-1:0]   o_credits,
  output logic            o_can_issue,
  output logic            o_overflow,
  output logic            o_proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = 3 * BITS + 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_in_flight;
  logic          r_overflow;
  logic          r_proto_err;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_orphan;
  logic [CW-1:0] w_in_flight_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW:0]   w_used;
  logic [CW:0]   w_room;
  logic [PW-1:0] w_head;

  // Downstream handshake: a word transfers on any cycle where o_valid && i_ready;
  // while o_valid is high and i_ready low the head fields stay unchanged.
  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_empty && i_ready;
  assign w_push   = i_valid && (!w_full || w_pop);
  assign w_drop   = i_valid && w_full && !w_pop;
  assign w_orphan = i_valid && !i_issue && (r_in_flight == '0);

  always_comb begin
    w_in_flight_nxt = r_in_flight;
    if (i_issue && !i_valid) begin
      if (r_in_flight != DEPTH_C) w_in_flight_nxt = r_in_flight + CW'(1);
    end else if (i_valid && !i_issue) begin
      if (r_in_flight != '0) w_in_flight_nxt = r_in_flight - CW'(1);
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_flight <= '0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_in_flight <= w_in_flight_nxt;
      if (w_drop)   r_overflow  <= 1'b1;
      if (w_orphan) r_proto_err <= 1'b1;
    end
  end

  // Payload storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_rot_en, i_mode, i_z, i_y, i_x};
  end

  assign w_head = r_mem[r_rd_ptr];

  // Credits come only from registered state, so the issuer sees them one cycle late.
  assign w_used = {1'b0, r_count} + {1'b0, r_in_flight};
  assign w_room = {1'b0, DEPTH_C} - w_used;
  assign o_credits   = (w_used >= {1'b0, DEPTH_C}) ? '0 : w_room[CW-1:0];
  assign o_can_issue = (o_credits != '0);

  assign o_valid     = !w_empty;
  assign o_x         = o_valid ? w_head[BITS-1:0]          : '0;
  assign o_y         = o_valid ? w_head[2*BITS-1:BITS]     : '0;
  assign o_z         = o_valid ? w_head[3*BITS-1:2*BITS]   : '0;
  assign o_mode      = o_valid ? w_head[3*BITS+1:3*BITS]   : 2'b00;
  assign o_rot_en    = o_valid ? w_head[PW-1]              : 1'b0;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_cordic_result_buffer.sv
`timescale 1ns/1ps
// Bench for cordic_result_buffer: a queue-based model of the buffer plus a
// fixed-latency stand-in for the CORDIC core, directed tables and random traffic.
module tb_cordic_result_buffer;

  localparam int BITS    = 33;
  localparam int DEPTH   = 16;
  localparam int CW      = $clog2(DEPTH + 1);
  localparam int PW      = 3 * BITS + 3;
  localparam int LATENCY = 13;

  logic            clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_issue = 1'b0;
  logic            i_valid = 1'b0;
  logic [BITS-1:0] i_x = '0;
  logic [BITS-1:0] i_y = '0;
  logic [BITS-1:0] i_z = '0;
  logic [1:0]      i_mode = '0;
  logic            i_rot_en = 1'b0;
  logic            i_ready = 1'b0;
  logic            o_valid;
  logic [BITS-1:0] o_x;
  logic [BITS-1:0] o_y;
  logic [BITS-1:0] o_z;
  logic [1:0]      o_mode;
  logic            o_rot_en;
  logic [CW-1:0]   o_count;
  logic [CW-1:0]   o_credits;
  logic            o_can_issue;
  logic            o_overflow;
  logic            o_proto_err;

  cordic_result_buffer #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_issue(i_issue), .i_valid(i_valid),
    .i_x(i_x), .i_y(i_y), .i_z(i_z), .i_mode(i_mode), .i_rot_en(i_rot_en),
    .i_ready(i_ready), .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_z(o_z),
    .o_mode(o_mode), .o_rot_en(o_rot_en), .o_count(o_count),
    .o_credits(o_credits), .o_can_issue(o_can_issue),
    .o_overflow(o_overflow), .o_proto_err(o_proto_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit last_iss = 1'b0;

  logic [PW-1:0] exp_q[$];
  int m_inflight = 0;
  bit m_ovf  = 1'b0;
  bit m_perr = 1'b0;

  typedef struct {
    int            due;
    logic [PW-1:0] pl;
  } pend_t;
  pend_t pipe[$];

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic int m_credits();
    int c = DEPTH - exp_q.size() - m_inflight;
    return (c < 0) ? 0 : c;
  endfunction

  function automatic bit may_issue();
    int c = m_credits();
    return (c >= 2) || (c == 1 && !last_iss);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    pipe.delete();
    m_inflight = 0;
    m_ovf      = 1'b0;
    m_perr     = 1'b0;
    last_iss   = 1'b0;
  endfunction

  function automatic void model_update();
    bit full = (exp_q.size() == DEPTH);
    bit pop  = (exp_q.size() != 0) && i_ready;
    bit push = i_valid && (!full || pop);
    if (i_valid && full && !pop) m_ovf = 1'b1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back({i_rot_en, i_mode, i_z, i_y, i_x});
    if (i_issue && !i_valid) begin
      m_inflight = (m_inflight < DEPTH) ? m_inflight + 1 : DEPTH;
    end else if (i_valid && !i_issue) begin
      if (m_inflight == 0) m_perr = 1'b1;
      else m_inflight--;
    end
  endfunction

  function automatic void check_model();
    logic [PW-1:0] head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("valid",     o_valid, exp_q.size() != 0);
    chk("head",      {o_rot_en, o_mode, o_z, o_y, o_x}, head);
    chk("count",     o_count, exp_q.size());
    chk("credits",   o_credits, m_credits());
    chk("can_issue", o_can_issue, m_credits() != 0);
    chk("overflow",  o_overflow, m_ovf);
    chk("proto_err", o_proto_err, m_perr);
  endfunction

  function automatic logic [PW-1:0] mk(input logic [BITS-1:0] x, input logic [BITS-1:0] y,
                                       input logic [BITS-1:0] z, input logic [1:0] m, input logic r);
    return {r, m, z, y, x};
  endfunction

  function automatic logic [PW-1:0] mkv(input int v);
    logic [BITS-1:0] xv = BITS'(v);
    return mk(xv, ~xv, BITS'(v * 3), 2'(v % 3), 1'(v & 1));
  endfunction

  function automatic logic [PW-1:0] mkrand();
    logic [63:0] a = {$urandom(), $urandom()};
    logic [63:0] b = {$urandom(), $urandom()};
    logic [31:0] c = $urandom();
    return mk(a[BITS-1:0], b[BITS-1:0], {c[0], a[63:32]}, c[2:1], c[3]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    check_model();
    cyc++;
  endtask

  task automatic drive(input bit iss, input bit val, input bit rdy, input logic [PW-1:0] pl);
    i_issue = iss;
    i_valid = val;
    i_ready = rdy;
    {i_rot_en, i_mode, i_z, i_y, i_x} = pl;
    last_iss = iss;
    step();
  endtask

  // Stand-in for the CORDIC core: every issued op returns LATENCY cycles later.
  task automatic core_cycle(input bit iss, input bit rdy, input logic [PW-1:0] pl);
    pend_t p;
    i_issue = iss;
    i_ready = rdy;
    if (pipe.size() != 0 && pipe[0].due == cyc) begin
      p = pipe.pop_front();
      i_valid = 1'b1;
      {i_rot_en, i_mode, i_z, i_y, i_x} = p.pl;
    end else begin
      i_valid = 1'b0;
      {i_rot_en, i_mode, i_z, i_y, i_x} = '0;
    end
    if (iss) begin
      p.due = cyc + LATENCY;
      p.pl  = pl;
      pipe.push_back(p);
    end
    last_iss = iss;
    step();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    {i_issue, i_valid, i_ready, i_rot_en, i_mode, i_z, i_y, i_x} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit            iss;
    bit            val;
    bit            rdy;
    logic [PW-1:0] pl;
    bit            e_valid;
    logic [PW-1:0] e_head;
    int            e_count;
    int            e_credits;
    bit            e_perr;
  } vec_t;

  initial begin
    vec_t tbl[10];
    logic [PW-1:0] pa, pb, pc, pd, pt;
    int v;

    pa = mk(33'h0_0000_0011, 33'h1_8000_0000, 33'h0_0F0F_0F0F, 2'b01, 1'b0);
    pb = mk(33'h1_2345_6789, 33'h0_0000_0001, 33'h1_FFFF_FFFE, 2'b00, 1'b1);
    pc = mk(33'h0_AAAA_5555, 33'h0_5555_AAAA, 33'h0_0000_0000, 2'b11, 1'b1);
    pd = mk(33'h1_0000_0000, 33'h0_7FFF_FFFF, 33'h0_1357_9BDF, 2'b01, 1'b1);
    tbl[0] = '{1, 0, 0, '0, 0, '0, 0, 15, 0};
    tbl[1] = '{1, 0, 0, '0, 0, '0, 0, 14, 0};
    tbl[2] = '{0, 1, 0, pa, 1, pa, 1, 14, 0};
    tbl[3] = '{0, 1, 0, pb, 1, pa, 2, 14, 0};
    tbl[4] = '{0, 0, 1, '0, 1, pb, 1, 15, 0};
    tbl[5] = '{0, 0, 1, '0, 0, '0, 0, 16, 0};
    tbl[6] = '{0, 0, 1, '0, 0, '0, 0, 16, 0};
    tbl[7] = '{0, 1, 0, pc, 1, pc, 1, 15, 1};
    tbl[8] = '{1, 1, 1, pd, 1, pd, 1, 15, 1};
    tbl[9] = '{0, 0, 1, '0, 0, '0, 0, 16, 1};

    // Reset idle state
    do_reset();
    check_model();
    chk("rst_credits", o_credits, 16);
    chk("rst_can_issue", o_can_issue, 1);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iss, tbl[i].val, tbl[i].rdy, tbl[i].pl);
      chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_head", i), {o_rot_en, o_mode, o_z, o_y, o_x}, tbl[i].e_head);
      chk($sformatf("tbl%0d_count", i), o_count, tbl[i].e_count);
      chk($sformatf("tbl%0d_credits", i), o_credits, tbl[i].e_credits);
      chk($sformatf("tbl%0d_perr", i), o_proto_err, tbl[i].e_perr);
    end

    // Single pass-through at core latency
    do_reset();
    pt = mk(33'h0_4000_0000, 33'h1_FFFF_FFFF, 33'h0_1234_5678, 2'b11, 1'b1);
    core_cycle(1, 1, pt);
    chk("pt_credits_issue", o_credits, 15);
    repeat (LATENCY - 1) core_cycle(0, 1, '0);
    chk("pt_not_yet", o_valid, 0);
    core_cycle(0, 1, '0);
    chk("pt_valid", o_valid, 1);
    chk("pt_fields", {o_rot_en, o_mode, o_z, o_y, o_x}, pt);
    core_cycle(0, 1, '0);
    chk("pt_popped", o_valid, 0);
    chk("pt_credits_back", o_credits, 16);

    // Backpressure fill 1..16 obeying the credit rule
    do_reset();
    v = 1;
    for (int n = 0; n < 200 && exp_q.size() != DEPTH; n++) begin
      if (v <= DEPTH && may_issue()) begin
        core_cycle(1, 0, mkv(v));
        v++;
      end else begin
        core_cycle(0, 0, '0);
      end
    end
    chk("fill_count", o_count, 16);
    chk("fill_can_issue", o_can_issue, 0);
    chk("fill_overflow", o_overflow, 0);

    // Simultaneous push/pop while full
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, mkv(17 + k));
      chk("fullpp_count", o_count, 16);
      chk("fullpp_head", o_x, BITS'(k + 2));
      chk("fullpp_ovf", o_overflow, 0);
    end

    // Forced overflow: contents unchanged
    drive(1, 1, 0, mkv(99));
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_count", o_count, 16);
    chk("ovf_head", {o_rot_en, o_mode, o_z, o_y, o_x}, mkv(4));
    chk("ovf_perr", o_proto_err, 0);

    // Drain in order across the pointer wrap
    for (int k = 0; k < 16; k++) begin
      chk("drain_x", o_x, BITS'(k + 4));
      drive(0, 0, 1, '0);
    end
    chk("drain_empty", o_valid, 0);
    chk("drain_credits", o_credits, 16);
    chk("drain_ovf_sticky", o_overflow, 1);

    // Protocol error: arrival with nothing in flight
    drive(0, 1, 0, mkv(50));
    chk("perr_flag", o_proto_err, 1);
    chk("perr_pushed", o_count, 1);
    drive(0, 0, 1, '0);

    // Async reset mid-burst with count=5, in_flight=3
    do_reset();
    for (int k = 0; k < 8; k++) core_cycle(1, 0, mkv(200 + k));
    for (int n = 0; n < 40 && exp_q.size() != 5; n++) core_cycle(0, 0, '0);
    chk("burst_count", o_count, 5);
    chk("burst_credits", o_credits, 8);
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("arst_credits", o_credits, 16);
    {i_issue, i_valid, i_ready, i_rot_en, i_mode, i_z, i_y, i_x} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    drive(0, 0, 0, '0);
    chk("arst_release_credits", o_credits, 16);
    chk("arst_release_valid", o_valid, 0);

    // Random traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit iss;
      bit rdy;
      rdy = ($urandom_range(0, 3) != 0) ^ (n >= 600 && n < 900);
      iss = may_issue() && ($urandom_range(0, 4) != 0);
      core_cycle(iss, rdy, mkrand());
    end
    for (int n = 0; n < 100 && (pipe.size() != 0 || exp_q.size() != 0); n++)
      core_cycle(0, 1, '0);
    chk("rand_drained", o_count, 0);
    chk("rand_ovf", o_overflow, 0);
    chk("rand_perr", o_proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_result_buffer.md
Name: cordic_result_buffer

Overview:
- Downstream companion of the pipelined CORDIC core.
- The core has no stall path: results emerge at a fixed latency regardless of consumer state. This block captures every result tuple (x, y, z, mode, rot_en) into a first-word-fall-through FIFO and presents it on a valid/ready interface.
- It tracks issued-but-not-yet-arrived operations and returns a credit to the upstream issuer. The issuer launches a CORDIC operation only when a FIFO slot is guaranteed, so no result is ever lost.

Parameters:
- BITS, 33, width of each x/y/z fixed-point word (signed); matches the core's INTEGER_BITS+FRACTIONAL_BITS.
- DEPTH, 16, FIFO entries; power of two, >= 2; sized to at least core latency + 1 (N_ITERATION+2) for full throughput.
- CW, $clog2(DEPTH+1), width of count/credit outputs (derived; do not override).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_issue  in  1  pulse: upstream launched one op into the core this cycle (same signal driven to the core's i_ready)
- i_valid  in  1  result strobe from core o_valid
- i_x  in  BITS  core o_x
- i_y  in  BITS  core o_y
- i_z  in  BITS  core o_z
- i_mode  in  2  core o_mode (signed: -1 hyperbolic, 0 linear, 1 circular)
- i_rot_en  in  1  core o_rot_en
- i_ready  in  1  downstream consumer ready
- o_valid  out  1  head entry valid
- o_x  out  BITS  head x
- o_y  out  BITS  head y
- o_z  out  BITS  head z
- o_mode  out  2  head mode
- o_rot_en  out  1  head rot_en
- o_count  out  CW  FIFO occupancy
- o_credits  out  CW  DEPTH - occupancy - in_flight, floored at 0
- o_can_issue  out  1  o_credits != 0
- o_overflow  out  1  sticky: result dropped because FIFO full
- o_proto_err  out  1  sticky: result arrived with in_flight == 0

Behaviour:
- Reset (i_rst_n low, async): FIFO pointers, count and in_flight = 0.
- Reset values: o_valid=0, o_x/o_y/o_z=0, o_mode=0, o_rot_en=0, o_count=0, o_credits=DEPTH, o_can_issue=1, o_overflow=0, o_proto_err=0.
- Reset mid-operation discards all stored and in-flight results. The system must reset the core in the same window; results arriving from a core not reset are handled as protocol errors (see below).
- Push: i_valid high and (count < DEPTH or pop this cycle).
  - Payload {rot_en, mode, z, y, x} is written at the write pointer.
- Pop: o_valid && i_ready. The read pointer advances.
- Outputs o_x..o_rot_en reflect the head entry combinationally from storage (FWFT).
  - Push into an empty FIFO gives o_valid=1 on the next cycle (latency 1 clock).
  - o_* hold stable while o_valid && !i_ready.
- Full plus simultaneous push and pop: both accepted; count unchanged.
- Empty plus i_ready: no pop; o_valid stays 0.
- Overflow: i_valid with count == DEPTH and no pop.
  - Data is dropped and o_overflow sets.
  - o_overflow clears only on reset.
  - Cannot occur if the issuer honours o_can_issue.
- in_flight counter, width CW:
  - +1 on i_issue, -1 on i_valid, unchanged when both occur in the same cycle.
  - i_valid with in_flight == 0 and no i_issue: in_flight stays 0, o_proto_err sets (sticky); the data is still pushed if space exists.
  - i_issue when o_can_issue == 0 is an issuer bug. in_flight still increments, saturating at DEPTH.
- Credit equation: o_credits = max(0, DEPTH - count - in_flight), from registered state (combinational subtraction, no input paths).
  - Updates the cycle after an issue, arrival or pop.
  - Issuer rule: at most one i_issue per cycle while o_can_issue=1. Because the credit is one cycle stale, the issuer may issue only if o_credits >= 2, or o_credits == 1 with no issue in the previous cycle.
- Pointers are log2(DEPTH) bits wide and wrap naturally. count is tracked explicitly, so full/empty decode from count.
- No arithmetic on payload; fields pass bit-exact.

Test Plan:
- Reset, then check idle values: o_valid=0, o_count=0, o_credits=16, o_can_issue=1, flags 0.
- Single pass-through:
  - Stimulus: i_issue 1 cycle; 13 cycles later i_valid with x=0x0_4000_0000, y=0x1_FFFF_FFFF, z=0x0_1234_5678, mode=-1, rot_en=1; i_ready=1.
  - Expect: o_valid one cycle after i_valid with identical fields; credits 15 after issue, back to 16 after pop.
- Backpressure fill:
  - Stimulus: i_ready=0; issue back-to-back per credit rule with values 1..N.
  - Expect: count reaches 16, o_can_issue=0, no overflow. With i_ready=1, values drain 1..16 in order across pointer wrap.
- Simultaneous push and pop while full: count stays 16, order preserved, o_overflow stays 0.
- Forced overflow and protocol error:
  - Overflow: i_valid while full with i_ready=0 sets o_overflow; the FIFO contents are unchanged.
  - Protocol error: i_valid with in_flight=0 sets o_proto_err.
- Async reset mid-burst:
  - Stimulus: assert i_rst_n=0 between clock edges with count=5, in_flight=3.
  - Expect: outputs go to reset values immediately; after release, o_credits=16.
